// File: rtl/mdu_unit_if.sv
// Handshake/status bundle between the E-stage control and the multiply/divide unit.
// Handshake: start is a one-cycle request qualified by md_op; it is accepted only
// while busy is low and flush is low. stall_req tells the hazard unit to hold any
// MD-class instruction in D. HI/LO are registered and readable every cycle.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             dbg_state;  // 1 = RUN, 0 = IDLE

  modport master (
    output start, md_op, A, B, flush,
    input  busy, stall_req, HI, LO, dbg_state
  );

  modport slave (
    input  start, md_op, A, B, flush,
    output busy, stall_req, HI, LO, dbg_state
  );
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit: behavioural mult/div on latched operands, released
// after a configurable number of busy cycles; also holds HI/LO and mthi/mtlo.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_unit_if.slave  bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;

  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
  logic               w_b_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_one, w_div_b, w_abs_a, w_abs_b, w_abs_bd;
  logic [WIDTH-1:0]   w_uq, w_ur, w_sq_mag, w_sr_mag, w_sq, w_sr;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic               w_res_we;
  logic               w_is_md;

  // Low 2W bits of an unsigned product of sign-extended operands equal the signed product.
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};

  // Signed division is done on magnitudes so the most-negative / -1 case
  // falls out naturally (quotient wraps to most-negative, remainder 0).
  // A zero divisor is replaced by 1 only to keep the operators defined;
  // the result is discarded in that case.
  assign w_one    = {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_b_zero = (r_b == '0);
  assign w_a_neg  = r_a[WIDTH-1];
  assign w_b_neg  = r_b[WIDTH-1];
  assign w_div_b  = w_b_zero ? w_one : r_b;
  assign w_abs_a  = w_a_neg ? -r_a : r_a;
  assign w_abs_b  = w_b_neg ? -r_b : r_b;
  assign w_abs_bd = w_b_zero ? w_one : w_abs_b;
  assign w_uq     = r_a / w_div_b;
  assign w_ur     = r_a % w_div_b;
  assign w_sq_mag = w_abs_a / w_abs_bd;
  assign w_sr_mag = w_abs_a % w_abs_bd;
  assign w_sq     = (w_a_neg ^ w_b_neg) ? -w_sq_mag : w_sq_mag;
  assign w_sr     = w_a_neg ? -w_sr_mag : w_sr_mag;

  // Select the HI/LO result for the latched operation.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      OP_MULT:  begin {w_res_hi, w_res_lo} = w_prod_s; w_res_we = 1'b1; end
      OP_MULTU: begin {w_res_hi, w_res_lo} = w_prod_u; w_res_we = 1'b1; end
      OP_DIV:   begin w_res_hi = w_sr; w_res_lo = w_sq; w_res_we = !w_b_zero; end
      OP_DIVU:  begin w_res_hi = w_ur; w_res_lo = w_uq; w_res_we = !w_b_zero; end
      default:  begin w_res_we = 1'b0; end
    endcase
  end

  assign w_is_md = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);

  // IDLE/RUN control, operand latch, busy counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (w_is_md) begin
              r_a     <= bus.A;
              r_b     <= bus.B;
              r_op    <= bus.md_op;
              r_cnt   <= (bus.md_op <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
              r_state <= S_RUN;
            end else if (bus.md_op == OP_MTHI) begin
              r_hi <= bus.A;
            end else if (bus.md_op == OP_MTLO) begin
              r_lo <= bus.A;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.dbg_state = (r_state == S_RUN);
  assign bus.stall_req = (r_state == S_RUN) | (bus.start & w_is_md);
  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a driver issues operations and pushes the
// expected {HI,LO}; a monitor pops and compares whenever busy drops.
module tb_mdu_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic prev_busy = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [2*W-1:0] exp_q[$];

  mdu_unit_if #(.WIDTH(W)) bus ();

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: completion of an operation (busy falls) releases the next expected result
  always @(negedge clk) begin
    if (prev_busy && !bus.busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected completion", {bus.HI, bus.LO}, {2*W{1'bx}});
      end else begin
        chk("result", {bus.HI, bus.LO}, exp_q.pop_front());
      end
    end
    prev_busy <= bus.busy;
  end

  // multi-cycle op issued at cycle T; ign_at>0 issues an mtlo during that busy cycle
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input int n,
                        input int ign_at);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    #1 chk({name, " stall_req at issue"}, 64'(bus.stall_req), 64'd1);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == ign_at) begin
        bus.start = 1'b1; bus.md_op = 3'd6; bus.A = 32'hDEAD_BEEF;
        #1 chk({name, " stall_req in run"}, 64'(bus.stall_req), 64'd1);
      end else begin
        bus.start = 1'b0; bus.md_op = 3'd0;
        bus.A = $urandom_range(32'hFFFF_FFFF, 0); bus.B = $urandom_range(32'hFFFF_FFFF, 0);
      end
      chk({name, " busy"}, 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 3'd0;
    chk({name, " busy end"}, 64'(bus.busy), 64'd0);
  endtask

  // zero-latency request in IDLE (mthi/mtlo/none), with expected {HI,LO} afterwards
  task automatic imm_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic fl, input logic [2*W-1:0] exp);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.flush = fl;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 3'd0; bus.flush = 1'b0;
    chk({name, " busy"}, 64'(bus.busy), 64'd0);
    chk({name, " hilo"}, {bus.HI, bus.LO}, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset hilo", {bus.HI, bus.LO}, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset stall_req", 64'(bus.stall_req), 64'd0);

    run_op("mult",   3'd1, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5, 0);
    run_op("multu",  3'd2, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 5, 0);
    run_op("div",    3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0);
    run_op("divu",   3'd4, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 10, 0);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 10, 0);

    imm_op("mthi", 3'd5, 32'h0000_1234, 1'b0, {32'h0000_1234, 32'h8000_0000});
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd6; bus.A = 32'h77;
    #1 chk("mtlo stall_req", 64'(bus.stall_req), 64'd0);
    bus.start = 1'b0; bus.md_op = 3'd0;
    imm_op("op7 none", 3'd7, 32'h0000_00FF, 1'b0, {32'h0000_1234, 32'h8000_0000});
    imm_op("op0 none", 3'd0, 32'h0000_00EE, 1'b0, {32'h0000_1234, 32'h8000_0000});
    imm_op("flush mthi", 3'd5, 32'h0000_BEEF, 1'b1, {32'h0000_1234, 32'h8000_0000});
    imm_op("flush mult", 3'd1, 32'h0000_0009, 1'b1, {32'h0000_1234, 32'h8000_0000});

    imm_op("mthi 11", 3'd5, 32'h11, 1'b0, {32'h11, 32'h8000_0000});
    imm_op("mtlo 22", 3'd6, 32'h22, 1'b0, {32'h11, 32'h22});
    run_op("divu by0", 3'd4, 32'h0000_0005, 32'h0, {32'h11, 32'h22}, 10, 0);

    // mult flushed in its third busy cycle: HI/LO keep 0x11/0x22
    exp_q.push_back({32'h11, 32'h22});
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd5; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 3'd0;
    chk("flush busy1", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("flush busy2", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    chk("flush busy3", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy after", 64'(bus.busy), 64'd0);

    // mtlo issued in the second busy cycle must be ignored
    run_op("mult ign", 3'd1, 32'd2, 32'd3, {32'h0, 32'h6}, 5, 2);
    repeat (3) @(negedge clk);
    chk("ignored mtlo lo", {32'h0, bus.LO}, {32'h0, 32'h6});
    chk("queue drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit in the E stage of the 5-stage pipeline.
- Executes mult/multu/div/divu with configurable multi-cycle latency and holds the HI/LO registers.
- Also performs mthi/mtlo writes.
- Exports busy/stall status so the hazard unit can stall D-stage MD-class instructions (mfhi/mflo/mult/div/mthi/mtlo) while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request: latch operands and md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  WIDTH  rs operand (forwarded value).
- B  input  WIDTH  rt operand (forwarded value).
- flush  input  1  cancel the in-flight operation.
- busy  output  1  operation in progress.
- stall_req  output  1  combinational: busy | (start & md_op in {1..4}).
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset: HI=0, LO=0, busy=0, internal counter=0, latched operands=0. Reset has priority over start and flush.
- States: IDLE, RUN. busy = (state==RUN).
- Accept in IDLE:
  - start=1 with md_op 1..4 latches A, B, op and counter=N-1, where N=MULT_CYCLES or DIV_CYCLES.
  - Next state is RUN.
  - Accept cycle T ⇒ busy=1 during cycles T+1..T+N.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==0: HI/LO are written and the state returns to IDLE.
  - Results are visible and busy=0 in cycle T+N+1.
- mthi/mtlo (start with md_op 5/6 in IDLE): HI or LO takes A on the next edge. Zero latency; busy never asserts.
- start during RUN (any md_op): ignored; no state change. The hazard unit guarantees this cannot occur; the bench checks that it is ignored.
- md_op 0/7 with start: no effect.
- Arithmetic (2*WIDTH-bit product):
  - mult: signed {HI,LO}=A*B.
  - multu: unsigned {HI,LO}=A*B.
  - div: signed LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divisor==0 (div/divu): full latency elapses; HI and LO stay unchanged.
- Signed overflow (div, A=most-negative, B=-1): LO=most-negative value, HI=0. No trap.
- flush:
  - In RUN, the next edge returns to IDLE with HI/LO unchanged and busy=0 the following cycle.
  - In IDLE, flush suppresses a same-cycle start: no latch, no HI/LO write.
- Results use only latched operands; changes on A/B during RUN have no effect.
- HI/LO are registered outputs, readable every cycle (mfhi/mflo path). Mid-operation they hold the previous values.
- Implementation may be iterative or a behavioural operator followed by a delay counter. Only the cycle timing above is contractual.

Test Plan:
- Reset, then read → HI=0, LO=0, busy=0, stall_req=0.
- start, mult, A=0xFFFFFFFE (-2), B=3 at cycle T:
  - stall_req=1 in T.
  - busy=1 for T+1..T+5.
  - In T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div, A=-7 (0xFFFFFFF9), B=2:
  - busy for 10 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu with same operands → LO=0x7FFFFFFC, HI=0x00000001.
- Edge cases:
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu B=0 with prior HI=0x11, LO=0x22 → after 10 busy cycles HI=0x11, LO=0x22.
- mthi A=0x1234 → HI=0x1234 next cycle, busy stays 0.
- Flush and ignore behaviour:
  - mult started, flush in the 3rd busy cycle → busy=0 the following cycle; HI/LO keep their old values.
  - mtlo issued during RUN → ignored; LO unchanged.
